// File: rtl/jt12_kon_sched_if.sv
// CPU-side write channel for the key-on scheduler: one reg 0x28 byte per valid/ready handshake.
interface jt12_kon_sched_if;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;

  modport master (output wr_valid, output wr_data, input  wr_ready);
  modport slave  (input  wr_valid, input  wr_data, output wr_ready);
endinterface

// File: rtl/jt12_kon_sched.sv
// Key-on scheduler: queues reg 0x28 writes and applies at most one per frame at the zero pulse,
// then serialises the per-slot key state onto o_keyon_I in EG slot order.
module jt12_kon_sched #(
  parameter int num_ch     = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_clk_en,
  input  logic                          i_zero,
  jt12_kon_sched_if.slave               wr_if,
  output logic                          o_keyon_I,
  output logic [4*num_ch-1:0]           o_kon_state,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_cnt,
  output logic                          o_err_inval
);

  localparam int SLOTS = 4 * num_ch;
  localparam int SP_W  = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } state_t;

  // Channel codes 0-2 map to ch 0-2, codes 4-6 to ch 3-5.
  function automatic logic [2:0] decode_ch(input logic [2:0] code);
    return {1'b0, code[1:0]} + (code[2] ? 3'd3 : 3'd0);
  endfunction

  function automatic logic code_valid(input logic [2:0] code);
    logic [2:0] ch;
    ch = decode_ch(code);
    return (code[1:0] != 2'b11) && (int'(ch) < num_ch);
  endfunction

  state_t             r_state;
  logic [7:0]         r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ready;
  logic               r_err;
  logic [SLOTS-1:0]   r_kon;
  logic [SP_W-1:0]    r_sp;
  logic               r_keyon;

  logic               w_push;
  logic               w_pop;
  logic [7:0]         w_head;
  logic [2:0]         w_head_ch;
  logic               w_head_ok;
  logic [3:0]         w_op_mask;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [SLOTS-1:0]   w_kon_new;
  logic               w_unused;

  assign w_push    = wr_if.wr_valid & r_ready;
  assign w_pop     = i_clk_en & i_zero & (r_state == ST_PEND);
  assign w_head    = r_mem[r_rd_ptr];
  assign w_head_ch = decode_ch(w_head[2:0]);
  assign w_head_ok = code_valid(w_head[2:0]);
  assign w_unused  = w_head[3];
  // Mask bits are S1,S2,S3,S4 but slot order is S1,S3,S2,S4.
  assign w_op_mask = {w_head[7], w_head[5], w_head[6], w_head[4]};

  // Occupancy after this cycle's push/pop.
  always_comb begin
    w_cnt_nxt = r_cnt;
    case ({w_push, w_pop})
      2'b10:   w_cnt_nxt = r_cnt + CNT_W'(1);
      2'b01:   w_cnt_nxt = r_cnt - CNT_W'(1);
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  // Key state after applying the popped command to its channel's four slots.
  always_comb begin
    w_kon_new = r_kon;
    if (w_pop && w_head_ok) begin
      for (int op = 0; op < 4; op++) begin
        for (int c = 0; c < num_ch; c++) begin
          if (w_head_ch == 3'(c)) begin
            w_kon_new[op*num_ch + c] = w_op_mask[op];
          end else begin
            w_kon_new[op*num_ch + c] = r_kon[op*num_ch + c];
          end
        end
      end
    end else begin
      w_kon_new = r_kon;
    end
  end

  // Command storage; contents are don't-care until pointed at by a valid count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_if.wr_data;
    end
  end

  // FIFO control, pending/idle FSM, back-pressure and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_cnt    <= {CNT_W{1'b0}};
      r_ready  <= 1'b1;
      r_err    <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        if (!w_head_ok) begin
          r_err <= 1'b1;
        end
      end
      r_cnt   <= w_cnt_nxt;
      r_ready <= (w_cnt_nxt != CNT_W'(FIFO_DEPTH));
      case (r_state)
        ST_IDLE: r_state <= w_push ? ST_PEND : ST_IDLE;
        ST_PEND: r_state <= (w_cnt_nxt == {CNT_W{1'b0}}) ? ST_IDLE : ST_PEND;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Slot engine: latch new key state at frame start, then walk slots once per clk_en.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_kon   <= {SLOTS{1'b0}};
      r_sp    <= {SP_W{1'b0}};
      r_keyon <= 1'b0;
    end else if (i_clk_en) begin
      if (i_zero) begin
        r_kon   <= w_kon_new;
        r_keyon <= w_kon_new[0];
        r_sp    <= SP_W'(1);
      end else begin
        r_keyon <= r_kon[r_sp];
        r_sp    <= (r_sp == SP_W'(SLOTS-1)) ? {SP_W{1'b0}} : r_sp + SP_W'(1);
      end
    end
  end

  assign wr_if.wr_ready = r_ready;
  assign o_keyon_I      = r_keyon;
  assign o_kon_state    = r_kon;
  assign o_fifo_cnt     = r_cnt;
  assign o_err_inval    = r_err;

endmodule
